// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity modes and default baud divisor.
// Imported by the transmitter and the matching receiver.
package uart_pkg;

    // 50 MHz system clock at 115200 baud.
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick on the last cycle of every CLKS_PER_BIT-cycle window while en is high.
// The counter is held at zero whenever en is low, so each frame starts on a fresh bit boundary.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_baud_tick: CLKS_PER_BIT must be at least 2");
    end

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CntLast);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional parity, one or two stop bits.
// One word is accepted per valid/ready handshake; the line idles high.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned BitW = $clog2(DATA_BITS + 1);
    localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..8");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick;
    logic                 handshake;

    assign handshake = tx_valid && ready_q;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != StIdle),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (handshake) state_d = StStart;
            StStart:  if (tick) state_d = StData;
            StData: begin
                if (tick && bit_cnt_q == LastData) begin
                    state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                end
            end
            StParity: if (tick) state_d = StStop;
            StStop:   if (tick && bit_cnt_q == LastStop) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are registered, so each branch sets the line level for the bit that starts next.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_d      = 1'b1;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                bit_cnt_d = '0;
                if (handshake) begin
                    shreg_d = tx_data;
                    par_d   = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (tick) begin
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_cnt_q == LastData) begin
                        bit_cnt_d = '0;
                        tx_d      = (PARITY != PAR_NONE) ? par_q : 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    tx_d = 1'b1;
                end
            end
            StStop: begin
                if (tick) begin
                    if (bit_cnt_q == LastStop) begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 7N2) at CLKS_PER_BIT=4.
// Stimulus pushes expected words; a line monitor rebuilds each frame and checks it cycle by cycle.
module tb_uart_tx_frame;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         hs;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] valid_v;
    logic [7:0] data_v [4];
    logic       tx_v   [4];
    logic       rdy_v  [4];
    logic       busy_v [4];
    logic       done_v [4];

    exp_t exp_q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   sel      = 0;
    bit   mon_en   = 1'b0;
    bit   mon_busy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (
        .clk(clk), .rst(rst), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
        .tx_ready(rdy_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0])
    );
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_8e1 (
        .clk(clk), .rst(rst), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
        .tx_ready(rdy_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1])
    );
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut_8o1 (
        .clk(clk), .rst(rst), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
        .tx_ready(rdy_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2])
    );
    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut_7n2 (
        .clk(clk), .rst(rst), .tx_data(data_v[3][6:0]), .tx_valid(valid_v[3]),
        .tx_ready(rdy_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3])
    );

    function automatic int cfg_db(input int i);
        return (i == 3) ? 7 : 8;
    endfunction

    function automatic int cfg_par(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction

    function automatic int cfg_sb(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: one full frame from the falling start edge through the tx_done cycle.
    task automatic check_frame();
        exp_t       e;
        int         db;
        int         np;
        int         nb;
        int         s;
        int         bad_k;
        int         ctl_err;
        logic [7:0] got;
        logic       eb;
        db      = cfg_db(sel);
        np      = (cfg_par(sel) != 0) ? 1 : 0;
        nb      = 1 + db + np + cfg_sb(sel);
        s       = cyc;
        bad_k   = -1;
        ctl_err = 0;
        got     = '0;
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dut%0d unexpected_start: got start bit at cycle %0d, expected idle line",
                     sel, s);
            repeat (4 * nb) @(negedge clk);
            mon_busy = 1'b0;
            return;
        end
        e = exp_q.pop_front();
        for (int k = 0; k <= 4 * nb; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 4 * nb) begin
                int b;
                b = k / 4;
                if (b == 0) eb = 1'b0;
                else if (b <= db) eb = e.data[b-1];
                else if (np == 1 && b == db + 1) eb = e.par;
                else eb = 1'b1;
                if (tx_v[sel] !== eb && bad_k < 0) bad_k = k;
                if (done_v[sel] !== 1'b0 || rdy_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) ctl_err++;
                if (k % 4 == 2 && b >= 1 && b <= db) got[b-1] = tx_v[sel];
            end else begin
                check($sformatf("dut%0d end_of_frame {done,ready,busy,tx}", sel),
                      int'({done_v[sel], rdy_v[sel], busy_v[sel], tx_v[sel]}), 'b1101);
            end
        end
        check($sformatf("dut%0d start_cycle", sel), s, e.hs);
        check($sformatf("dut%0d first_bad_line_cycle", sel), bad_k, -1);
        check($sformatf("dut%0d in_frame_ctrl_errors", sel), ctl_err, 0);
        check($sformatf("dut%0d decoded_word", sel), int'(got), int'(e.data));
        mon_busy = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en && tx_v[sel] === 1'b0) check_frame();
        end
    end

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic send(input int idx, input logic [7:0] w, input logic p, input bit keep,
                        output int hs);
        int n;
        n = 0;
        data_v[idx]  = w;
        valid_v[idx] = 1'b1;
        while (rdy_v[idx] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d handshake_ready", idx), int'(rdy_v[idx] === 1'b1), 1);
        hs = cyc + 1;
        if (mon_en) exp_q.push_back('{data: w, par: p, hs: cyc + 1});
        @(negedge clk);
        if (!keep) valid_v[idx] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mon_busy || exp_q.size() != 0 || rdy_v[sel] !== 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d return_to_idle", sel), int'(n < 400), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int hs1;
        int hs2;
        int bad;
        rst     = 1'b1;
        valid_v = '0;
        for (int i = 0; i < 4; i++) data_v[i] = '0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dut%0d reset {tx,ready,busy,done}", i),
                  int'({tx_v[i], rdy_v[i], busy_v[i], done_v[i]}), 'b1000);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) check($sformatf("dut%0d ready_after_reset", i), int'(rdy_v[i]), 1);
        mon_en = 1'b1;

        // 8N1, 0x55
        sel = 0;
        send(0, 8'h55, 1'b0, 1'b0, hs1);
        wait_idle();

        // 8E1 and 8O1, 0x07: three ones, so even parity bit 1, odd parity bit 0
        sel = 1;
        send(1, 8'h07, 1'b1, 1'b0, hs1);
        wait_idle();
        sel = 2;
        send(2, 8'h07, 1'b0, 1'b0, hs1);
        wait_idle();

        // Back-to-back with tx_valid held
        sel = 0;
        send(0, 8'hA5, 1'b0, 1'b1, hs1);
        send(0, 8'h3C, 1'b0, 1'b0, hs2);
        check("dut0 back_to_back_period", hs2 - hs1, 41);
        wait_idle();

        // Reset during data bit 3 of 0xF0 (bit 3 occupies edges hs+16..hs+19)
        mon_en = 1'b0;
        send(0, 8'hF0, 1'b0, 1'b0, hs1);
        repeat (17) @(negedge clk);
        check("dut0 abort_bit3_low", int'(tx_v[0]), 0);
        rst = 1'b1;
        @(negedge clk);
        check("dut0 abort_in_reset {tx,ready,busy,done}",
              int'({tx_v[0], rdy_v[0], busy_v[0], done_v[0]}), 'b1000);
        @(negedge clk);
        check("dut0 abort_in_reset2 {ready,done}", int'({rdy_v[0], done_v[0]}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("dut0 abort_ready_after_release", int'(rdy_v[0]), 1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) bad++;
            @(negedge clk);
        end
        check("dut0 abort_no_done_line_high", bad, 0);
        mon_en = 1'b1;
        send(0, 8'h12, 1'b0, 1'b0, hs1);
        wait_idle();

        // 7N2, 0x7F
        sel = 3;
        send(3, 8'h7F, 1'b0, 1'b0, hs1);
        wait_idle();

        // Mid-frame churn on tx_data/tx_valid while sending 0x81
        sel = 0;
        send(0, 8'h81, 1'b0, 1'b0, hs1);
        for (int i = 0; i < 30; i++) begin
            data_v[0]  = 8'(i * 37);
            valid_v[0] = i[0];
            @(negedge clk);
        end
        valid_v[0] = 1'b0;
        wait_idle();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_v[0] !== 1'b1 || rdy_v[0] !== 1'b1) bad++;
            @(negedge clk);
        end
        check("dut0 no_extra_frame", bad, 0);

        check("scoreboard_left_over", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Serial frame transmitter that drives the single-wire line monitored by the team's edge detectors and receivers.
- Accepts one parallel data word per valid/ready handshake.
- Serialises it LSB-first as start bit, data bits, optional parity bit and stop bit(s), each held for a fixed number of clock cycles.
- Idle line level is high, so the start bit is a falling edge for the receiving end.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range >= 2
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
tx_data  input  DATA_BITS  word to send; sampled only on handshake
tx_valid  input  1  upstream has a word
tx_ready  output  1  block can accept a word (IDLE)
tx  output  1  serial line, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse after final stop bit completes

Behaviour:
- Reset and clocking: one clock domain (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Values while rst is high: tx=1, tx_ready=0, tx_busy=0, tx_done=0, FSM=IDLE, counters=0.
- First cycle after rst deasserts: tx_ready=1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_ready=1.
  - Handshake occurs at an edge where tx_valid=1 and tx_ready=1.
  - At that edge: latch tx_data into the shift register and compute the parity bit. Odd parity is ~^data; even parity is ^data.
  - Same edge: go to START, tx<=0, tx_ready<=0, tx_busy<=1.
- Bit timing: a baud counter counts 0..CLKS_PER_BIT-1. Each state/bit lasts exactly CLKS_PER_BIT cycles. Bit transitions happen on the edge where the counter wraps.
- START: tx=0 → DATA.
- DATA: tx = shift register bit 0, then shift right. After DATA_BITS bits → PARITY if PARITY != 0, else STOP.
- PARITY: tx = latched parity bit → STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles → IDLE. At that edge: tx_done<=1 for one cycle, tx_ready<=1, tx_busy<=0.
- Frame length: N = CLKS_PER_BIT*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles from handshake edge to tx_ready reassertion.
- Back-to-back frames: with tx_valid held high, the next handshake occurs one cycle after tx_ready rises.
  - Handshake-to-handshake period is N+1.
  - The line stays high for that extra cycle; this is legal stop-bit extension.
- tx_valid or tx_data changes during a frame are ignored. No handshake is possible while tx_ready=0.
- Reset mid-frame: the frame is aborted, tx=1 from the next edge, and no tx_done is generated.
- tx_done and tx_ready=1 are never asserted during rst.
- Elaboration error for:
  - CLKS_PER_BIT < 2
  - DATA_BITS outside 5..8
  - PARITY > 2
  - STOP_BITS not 1 or 2
- Counter widths: $clog2(CLKS_PER_BIT) for the baud counter, $clog2(DATA_BITS+1) for the bit counter. The baud counter never exceeds CLKS_PER_BIT-1.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum uart_tx_state_t (IDLE/START/DATA/PARITY/STOP)
  - parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2
  - default CLKS_PER_BIT constant
  These are reused by the matching receiver.
- One sub-module: uart_baud_tick.
  - Parameter CLKS_PER_BIT; inputs clk, rst, en.
  - Output tick: one cycle per bit period; the counter is cleared when en=0.
  - The FSM enables it outside IDLE.

Test Plan:
All scenarios use CLKS_PER_BIT=4.
- 8N1, send 0x55 → from the cycle after handshake, tx = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. tx_done pulses at cycle 40. tx_ready=1 at cycle 40.
- PARITY=2, send 0x07 → parity bit 1; PARITY=1, send 0x07 → parity bit 0. Frame is 44 cycles, tx_done at 44.
- 8N1, tx_valid held with 0xA5 then 0x3C → second handshake exactly 41 cycles after the first. The second start bit falls at cycle 41. Both words decode LSB-first correctly.
- Assert rst for 2 cycles during data bit 3 of 0xF0 → tx=1 on the next edge, tx_ready=0 while in reset, tx_ready=1 after release, no tx_done. A following frame of 0x12 is clean.
- DATA_BITS=7, STOP_BITS=2, send 0x7F → frame is 1 low start bit, 7 high data bits, 2 high stop bits = 40 cycles. tx_done at 40.
- Change tx_data and toggle tx_valid mid-frame while sending 0x81 → serial output is still exactly 0x81, and there is no extra handshake until tx_ready=1.
